// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-read-port register file: read ports, write port,
// reservation port and status. The master drives requests, the slave (the regfile) responds.
interface regfile_mp_sb_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WORD_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;

  // Write handshake: a write is taken on a rising edge where wr_en and
  // wr_ready are both 1; wr_en may be held while wr_ready is 0, but nothing is queued.
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WORD_W-1:0]        wr_data;
  logic                     wr_ready;

  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;

  logic                     init_done;
  logic                     fsm_state;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_pending, wr_ready, init_done, fsm_state
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_pending, wr_ready, init_done, fsm_state
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass, optional zero register
// and a per-entry pending-write scoreboard; clears itself one entry per cycle after reset.
module regfile_mp_sb #(
  parameter int ADDR_W   = 5,
  parameter int WORD_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_sb_if.slave bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_nxt;
  logic [DEPTH-1:0]  pending;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              wr_fire;
  logic              rsv_fire;

  // An index is usable when it lies inside the array and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !(ZERO_REG && (a == '0));
  endfunction

  assign bus.wr_ready  = (state == READY);
  assign bus.init_done = (state == READY);
  assign bus.fsm_state = state;

  assign wr_fire  = bus.wr_en  && (state == READY) && addr_ok(bus.wr_addr);
  assign rsv_fire = bus.rsv_en && (state == READY) && addr_ok(bus.rsv_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nxt   = READY;
          clr_idx_nxt = '0;
        end
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Reservation is applied after the write so a same-edge new producer keeps the entry pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (wr_fire)  pending[bus.wr_addr]  <= 1'b0;
      if (rsv_fire) pending[bus.rsv_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_fire) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  logic [WORD_W-1:0] rdat [NUM_RD];
  logic              rpnd [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ok;
    logic              hit;

    assign ra  = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign ok  = (state == READY) && addr_ok(ra);
    assign hit = BYPASS && wr_fire && (bus.wr_addr == ra);

    assign rdat[g] = !ok ? '0 : (hit ? bus.wr_data : mem[ra]);
    assign rpnd[g] = ok && !hit && pending[ra];
  end

  always_comb begin
    bus.rd_data    = '0;
    bus.rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*WORD_W +: WORD_W] = rdat[i];
      bus.rd_pending[i]               = rpnd[i];
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two instances (default config and a 24-entry,
// no-zero-register, no-bypass config) share one stimulus stream, each with its own model.
module tb_regfile_mp_sb;

  localparam int AW   = 5;
  localparam int WW   = 32;
  localparam int NR   = 2;
  localparam int NDUT = 2;
  localparam int DEPTH_C [NDUT] = '{32, 24};
  localparam bit ZERO_C  [NDUT] = '{1'b1, 1'b0};
  localparam bit BYP_C   [NDUT] = '{1'b1, 1'b0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // stimulus
  logic [AW-1:0] rd_a [NR];
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [WW-1:0] wr_data_s;
  logic          rsv_en_s;
  logic [AW-1:0] rsv_addr_s;

  regfile_mp_sb_if #(.ADDR_W(AW), .WORD_W(WW), .NUM_RD(NR)) bus_a ();
  regfile_mp_sb_if #(.ADDR_W(AW), .WORD_W(WW), .NUM_RD(NR)) bus_b ();

  assign bus_a.rd_addr  = {rd_a[1], rd_a[0]};
  assign bus_a.wr_en    = wr_en_s;
  assign bus_a.wr_addr  = wr_addr_s;
  assign bus_a.wr_data  = wr_data_s;
  assign bus_a.rsv_en   = rsv_en_s;
  assign bus_a.rsv_addr = rsv_addr_s;
  assign bus_b.rd_addr  = {rd_a[1], rd_a[0]};
  assign bus_b.wr_en    = wr_en_s;
  assign bus_b.wr_addr  = wr_addr_s;
  assign bus_b.wr_data  = wr_data_s;
  assign bus_b.rsv_en   = rsv_en_s;
  assign bus_b.rsv_addr = rsv_addr_s;

  regfile_mp_sb #(
    .ADDR_W(AW), .WORD_W(WW), .DEPTH(DEPTH_C[0]), .NUM_RD(NR),
    .ZERO_REG(ZERO_C[0]), .BYPASS(BYP_C[0])
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  regfile_mp_sb #(
    .ADDR_W(AW), .WORD_W(WW), .DEPTH(DEPTH_C[1]), .NUM_RD(NR),
    .ZERO_REG(ZERO_C[1]), .BYPASS(BYP_C[1])
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // model and scoreboard
  logic [WW-1:0] mem_m   [NDUT][32];
  logic [31:0]   pend_m  [NDUT];
  int            edge_cnt[NDUT];
  bit            ready_m [NDUT];
  logic [WW:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit dropped(input int d, input logic [AW-1:0] a);
    return (int'(a) >= DEPTH_C[d]) || (ZERO_C[d] && (a == '0));
  endfunction

  // Expected {pending, data} for a read of address a on instance d this cycle.
  function automatic logic [WW:0] model_read(input int d, input logic [AW-1:0] a);
    if (!ready_m[d] || dropped(d, a)) return '0;
    if (BYP_C[d] && wr_en_s && (wr_addr_s == a)) return {1'b0, wr_data_s};
    return {pend_m[d][a], mem_m[d][a]};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < NDUT; d++) begin
      if (!rst) continue;
      if (!ready_m[d]) begin
        edge_cnt[d]++;
        if (edge_cnt[d] == DEPTH_C[d]) begin
          ready_m[d] = 1'b1;
          for (int k = 0; k < 32; k++) mem_m[d][k] = '0;
        end
      end else begin
        if (wr_en_s && !dropped(d, wr_addr_s)) begin
          mem_m[d][wr_addr_s]  = wr_data_s;
          pend_m[d][wr_addr_s] = 1'b0;
        end
        if (rsv_en_s && !dropped(d, rsv_addr_s)) pend_m[d][rsv_addr_s] = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [WW:0] exp;
    logic [WW:0] obs;
    for (int d = 0; d < NDUT; d++) begin
      for (int p = 0; p < NR; p++) begin
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          obs = (d == 0) ? {bus_a.rd_pending[p], bus_a.rd_data[p*WW +: WW]}
                         : {bus_b.rd_pending[p], bus_b.rd_data[p*WW +: WW]};
          check_eq($sformatf("rd dut%0d port%0d addr%0d", d, p, rd_a[p]), 64'(obs), 64'(exp));
        end
      end
    end
    check_eq("init_done a", 64'(bus_a.init_done), 64'(ready_m[0]));
    check_eq("wr_ready a",  64'(bus_a.wr_ready),  64'(ready_m[0]));
    check_eq("fsm_state a", 64'(bus_a.fsm_state), 64'(ready_m[0]));
    check_eq("init_done b", 64'(bus_b.init_done), 64'(ready_m[1]));
    check_eq("wr_ready b",  64'(bus_b.wr_ready),  64'(ready_m[1]));
  endtask

  // One clock: push expectations for the driven inputs, check before the edge, advance the model.
  task automatic cycle();
    for (int d = 0; d < NDUT; d++)
      for (int p = 0; p < NR; p++) exp_q.push_back(model_read(d, rd_a[p]));
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input int hold);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      ready_m[d]  = 1'b0;
      edge_cnt[d] = 0;
      pend_m[d]   = '0;
    end
    #1;
    check_eq("async init_done a", 64'(bus_a.init_done), 64'(0));
    check_eq("async init_done b", 64'(bus_b.init_done), 64'(0));
    check_eq("async rd_pending a", 64'(bus_a.rd_pending), 64'(0));
    check_eq("async rd_pending b", 64'(bus_b.rd_pending), 64'(0));
    repeat (hold) cycle();
    rst = 1'b1;
  endtask

  task automatic idle_wr();
    wr_en_s  = 1'b0;
    rsv_en_s = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_a[0] = a0;
    rd_a[1] = a1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    wr_en_s = 1'b0; wr_addr_s = '0; wr_data_s = '0;
    rsv_en_s = 1'b0; rsv_addr_s = '0;
    set_rd(5'd0, 5'd0);
    for (int d = 0; d < NDUT; d++) pend_m[d] = '0;
    #2;

    // reset, abort sweep at clr_idx 10, reset again and run full sweep
    apply_reset(2);
    repeat (10) cycle();
    apply_reset(1);

    // write/reserve held through the sweep must not be taken
    wr_en_s = 1'b1; wr_addr_s = 5'd5; wr_data_s = 32'h1111_2222;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd7;
    set_rd(5'd5, 5'd7);
    repeat (DEPTH_C[1]) cycle();
    idle_wr();
    repeat (DEPTH_C[0] - DEPTH_C[1]) cycle();

    for (int a = 0; a < 32; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      cycle();
    end

    // bypass vs no-bypass on the same write
    set_rd(5'd5, 5'd5);
    wr_en_s = 1'b1; wr_addr_s = 5'd5; wr_data_s = 32'hDEAD_BEEF;
    cycle();
    idle_wr();
    cycle();

    // zero register: write and reserve x0
    set_rd(5'd0, 5'd0);
    wr_en_s = 1'b1; wr_addr_s = 5'd0; wr_data_s = 32'h1234_5678;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd0;
    cycle();
    idle_wr();
    repeat (2) cycle();

    // reservation held, then cleared by the producer's write
    set_rd(5'd7, 5'd7);
    rsv_en_s = 1'b1; rsv_addr_s = 5'd7;
    cycle();
    idle_wr();
    repeat (3) cycle();
    wr_en_s = 1'b1; wr_addr_s = 5'd7; wr_data_s = 32'h0000_00A5;
    cycle();
    idle_wr();
    cycle();

    // same-edge write and reserve: data lands, entry stays pending
    set_rd(5'd9, 5'd7);
    wr_en_s = 1'b1; wr_addr_s = 5'd9; wr_data_s = 32'hCAFE_0009;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd9;
    cycle();
    idle_wr();
    repeat (2) cycle();

    // address 30: in range for the 32-entry instance, dropped for the 24-entry one
    set_rd(5'd30, 5'd23);
    wr_en_s = 1'b1; wr_addr_s = 5'd30; wr_data_s = 32'h3030_3030;
    rsv_en_s = 1'b1; rsv_addr_s = 5'd30;
    cycle();
    idle_wr();
    cycle();
    for (int a = 0; a < 32; a += 2) begin
      set_rd(AW'(a), AW'(a + 1));
      cycle();
    end

    // random traffic, reads biased toward the write address to exercise bypass
    repeat (300) begin
      wr_en_s    = 1'($urandom_range(0, 1));
      wr_addr_s  = AW'($urandom_range(0, 31));
      wr_data_s  = $urandom;
      rsv_en_s   = 1'($urandom_range(0, 1));
      rsv_addr_s = ($urandom_range(0, 3) == 0) ? wr_addr_s : AW'($urandom_range(0, 31));
      rd_a[0]    = ($urandom_range(0, 2) == 0) ? wr_addr_s : AW'($urandom_range(0, 31));
      rd_a[1]    = ($urandom_range(0, 2) == 0) ? rd_a[0]   : AW'($urandom_range(0, 31));
      cycle();
    end
    idle_wr();

    // reset in READY with x3 pending
    set_rd(5'd3, 5'd3);
    wr_en_s = 1'b1; wr_addr_s = 5'd3; wr_data_s = 32'h0000_0333;
    cycle();
    idle_wr();
    rsv_en_s = 1'b1; rsv_addr_s = 5'd3;
    cycle();
    idle_wr();
    cycle();
    apply_reset(1);
    repeat (DEPTH_C[0]) cycle();
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port register file with write-to-read bypass, optional hardwired zero register, and a per-register pending-write scoreboard.
- After reset it runs a one-entry-per-cycle clear sweep, then accepts traffic.
- Sits in the decode/writeback stage of the pipelined core.
- Replaces the single-mode two-read-port register file.

Parameters:
- ADDR_W, 5, register index width.
- WORD_W, 32, data word width.
- DEPTH, 32, number of entries (at most 2^ADDR_W).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, when 1 a same-cycle accepted write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WORD_W  read data, combinational; port i at [i*WORD_W +: WORD_W].
- rd_pending  out  NUM_RD  1 = register read on port i has an outstanding reservation.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  WORD_W  write data.
- wr_ready  out  1  write accepted this cycle when wr_en & wr_ready.
- rsv_en  in  1  reserve (mark pending) register rsv_addr.
- rsv_addr  in  ADDR_W  reservation index.
- init_done  out  1  clear sweep finished; block operational.

Behaviour:
- Reset (rst=0), asynchronous: state=CLEAR, clr_idx=0, all pending bits=0, init_done=0, wr_ready=0. Array not reset asynchronously.
- CLEAR state, each cycle: entry[clr_idx]<=0, clr_idx++. In the cycle clr_idx==DEPTH-1, the state moves to READY on that edge.
- CLEAR exit timing: init_done=1 and wr_ready=1 from the DEPTH-th edge after rst deasserts.
- In CLEAR: wr_en and rsv_en are ignored (not queued); all rd_data=0; all rd_pending=0.
- Reset asserted mid-sweep or in READY: immediate return to CLEAR. Sweep restarts at 0; scoreboard cleared.
- READY write: on edge with wr_en=1, entry[wr_addr]<=wr_data and pending[wr_addr]<=0.
- Writes dropped when:
  - wr_addr>=DEPTH;
  - ZERO_REG=1 and wr_addr==0.
- READY reserve: on edge with rsv_en=1, pending[rsv_addr]<=1. Ignored under the same drop rules as writes.
- Simultaneous write and reserve to the same address: entry takes wr_data and pending ends 1 (new producer wins).
- Read port i, combinational, priority order:
  - (a) ZERO_REG and addr==0 -> 0;
  - (b) addr>=DEPTH -> 0;
  - (c) BYPASS and wr_en & wr_ready & wr_addr==addr and write not dropped -> wr_data;
  - (d) otherwise entry[addr].
- rd_pending[i] = pending[addr], forced 0 in cases (a), (b) and (c).
- With BYPASS=0, a read of the address being written returns the old value until after the edge.
- Several read ports on the same address return identical data and pending.
- No other sequential latency: reads are 0-cycle; a write is visible without bypass on the next cycle.

Test Plan:
- Release rst, DEPTH=32 -> init_done=0 for 31 edges, 1 after edge 32; wr_en held 1 before that is not accepted. After init, every rd_addr reads 0.
- READY: write x5<=0xDEADBEEF, BYPASS=1, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF combinationally. With BYPASS=0 -> old value 0, then 0xDEADBEEF next cycle.
- ZERO_REG=1: write x0<=0x12345678, rsv x0 -> rd_data=0 and rd_pending=0 on all ports forever.
- rsv x7, then 3 idle cycles -> rd_pending for x7 =1 each cycle. Write x7<=0xA5 -> pending 0 after edge. Same-edge rsv+write x9 -> x9=wr_data, pending 1.
- DEPTH=24, ADDR_W=5: write addr 30 -> dropped; rd addr 30 -> 0, pending 0; entries 0..23 unchanged.
- Pull rst low mid-sweep (clr_idx=10) and in READY with x3 pending -> init_done=0 at once, pending cleared, sweep restarts taking the full DEPTH cycles, x3 reads 0.
